// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and default sizing shared by the fifo write arbiter.
// Consumed by fifo_wr_arbiter and rr_picker.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_CNT_WIDTH   = 4;
  localparam int DEF_ACK_TIMEOUT = 4;
  localparam int DEF_HIGH_WM     = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_t;

  // Successor of idx in a ring of n entries.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search; returns the first valid index
// at or after rr_ptr, wrapping at NUM_REQ.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int  pos_s;
  logic hit_s;

  // Walk the ring starting at rr_ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos_s = 0;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s = (int'(rr_ptr) + k >= NUM_REQ) ? int'(rr_ptr) + k - NUM_REQ : int'(rr_ptr) + k;
      hit_s = !found && req_valid[pos_s];
      idx   = hit_s ? IDX_W'(pos_s) : idx;
      found = found | req_valid[pos_s];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter driving one fifo write port, with ack/err/timeout completion.
// Define FIFO_ARB_WATERMARK_EN to also hold off new grants once fifo_count reaches HIGH_WM.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int HIGH_WM     = DEF_HIGH_WM,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic [CNT_WIDTH-1:0]          fifo_count,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_wr_err,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          wr_retry,
  output logic                          timeout_err
);

  localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);

  arb_state_t             state_r;
  logic [IDX_W-1:0]       rr_ptr_r;
  logic [IDX_W-1:0]       grant_r;
  logic [TCNT_W-1:0]      tcnt_r;
  logic                   wr_en_r;
  logic [DATA_WIDTH-1:0]  din_r;
  logic [NUM_REQ-1:0]     ready_r;
  logic                   busy_r;
  logic                   retry_r;
  logic                   tmo_r;

  logic                   pick_found_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   wm_hit_s;
  logic                   block_s;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_r),
    .found     (pick_found_s),
    .idx       (pick_idx_s)
  );

  assign wm_hit_s = (fifo_count >= CNT_WIDTH'(HIGH_WM));
`ifdef FIFO_ARB_WATERMARK_EN
  assign block_s = fifo_full | wm_hit_s;
`else
  logic unused_wm_s;
  assign unused_wm_s = wm_hit_s;
  assign block_s     = fifo_full;
`endif

  // Arbitration FSM; the pointer only advances on a clean ack so a failed word is retried first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      tcnt_r   <= '0;
      wr_en_r  <= 1'b0;
      din_r    <= '0;
      ready_r  <= '0;
      busy_r   <= 1'b0;
      retry_r  <= 1'b0;
      tmo_r    <= 1'b0;
    end else begin
      ready_r <= '0;
      retry_r <= 1'b0;
      tmo_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_found_s && !block_s) begin
            state_r <= WRITE;
            wr_en_r <= 1'b1;
            din_r   <= req_data[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
            grant_r <= pick_idx_s;
            busy_r  <= 1'b1;
          end
        end
        WRITE: begin
          state_r <= WAIT_ACK;
          wr_en_r <= 1'b0;
          tcnt_r  <= '0;
        end
        WAIT_ACK: begin
          // Simultaneous ack and err counts as an error.
          if (fifo_wr_err) begin
            retry_r <= 1'b1;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (fifo_wr_ack) begin
            ready_r  <= NUM_REQ'(1) << grant_r;
            rr_ptr_r <= IDX_W'(next_idx(int'(grant_r), NUM_REQ));
            state_r  <= IDLE;
            busy_r   <= 1'b0;
          end else if (tcnt_r == TCNT_W'(ACK_TIMEOUT - 1)) begin
            tmo_r   <= 1'b1;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = ready_r;
  assign fifo_wr_en  = wr_en_r;
  assign fifo_din    = din_r;
  assign grant_id    = grant_r;
  assign busy        = busy_r;
  assign wr_retry    = retry_r;
  assign timeout_err = tmo_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench with a behavioural 8-deep fifo, a vector table,
// directed corner sequences and a randomized run checked against a transaction-level model.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int TMO = 4;
  localparam int HWM = 6;
`ifdef FIFO_ARB_WATERMARK_EN
  localparam int LIMIT = HWM;
`else
  localparam int LIMIT = 8;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic [CW-1:0]   fifo_count;
  logic            fifo_wr_ack, fifo_wr_err, fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic            busy, wr_retry, timeout_err;

  // Fifo model controls: resp_mode 0 = ack, 1 = forced err, 2 = no response.
  int          resp_mode = 0;
  logic        rd_req = 1'b0;
  logic        f_clear = 1'b0;
  logic [31:0] fq[$];
  int          f_cnt = 0;
  logic        f_ack = 1'b0, f_err = 1'b0;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .ACK_TIMEOUT(TMO), .HIGH_WM(HWM)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy),
    .wr_retry(wr_retry), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign fifo_count  = CW'(f_cnt);
  assign fifo_full   = (f_cnt >= 8);
  assign fifo_wr_ack = f_ack;
  assign fifo_wr_err = f_err;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural fifo write port: ack/err one cycle after a sampled write.
  always @(posedge clk) begin
    f_ack <= 1'b0;
    f_err <= 1'b0;
    if (f_clear) begin
      fq.delete();
    end else begin
      if (fifo_wr_en) begin
        if (fq.size() >= 8 || resp_mode == 1) f_err <= 1'b1;
        else if (resp_mode == 0) begin
          fq.push_back(fifo_din);
          f_ack <= 1'b1;
        end
      end
      if (rd_req && fq.size() > 0) void'(fq.pop_front());
    end
    f_cnt <= fq.size();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; f_clear = 1'b1; req_valid = '0; rd_req = 1'b0; resp_mode = 0;
    repeat (2) @(negedge clk);
    f_clear = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = fifo_wr_en;
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] valid;
    int           resp;
    int           grant;
    logic [N-1:0] ready;
    logic         retry;
    logic         tmo;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [9];
    bit ok, seen;
    int pulses, retries, w, bad, last, lat;
    logic [N-1:0] ready_acc;
    logic         pulse_acc;
    // random-phase model state
    int m_ptr, pend, pkind, cur_g, exp_g, r;
    bit exp_wr;
    logic [31:0] exp_d;
    logic [N-1:0] exp_ready_v;
    logic exp_retry_v, exp_tmo_v;

    tbl[0] = '{4'b0001, 0, 0, 4'b0001, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 0, 1, 4'b0010, 1'b0, 1'b0};
    tbl[2] = '{4'b1001, 0, 3, 4'b1000, 1'b0, 1'b0};
    tbl[3] = '{4'b0110, 1, 1, 4'b0000, 1'b1, 1'b0};
    tbl[4] = '{4'b0110, 0, 1, 4'b0010, 1'b0, 1'b0};
    tbl[5] = '{4'b1000, 2, 3, 4'b0000, 1'b0, 1'b1};
    tbl[6] = '{4'b1100, 0, 2, 4'b0100, 1'b0, 1'b0};
    tbl[7] = '{4'b1001, 0, 3, 4'b1000, 1'b0, 1'b0};
    tbl[8] = '{4'b0011, 0, 0, 4'b0001, 1'b0, 1'b0};

    // Reset state, released at 7ns
    #6;
    check("reset_outputs", {req_ready, fifo_wr_en, fifo_din, grant_id, busy, wr_retry, timeout_err}, 64'd0);
    #1 reset_n = 1'b1;

    // Single producer streams words 1..8 into an empty fifo
    w = 1; req_data[31:0] = 32'd1; req_valid = 4'b0001; pulses = 0; retries = 0;
    repeat (60) begin
      @(negedge clk);
      if (wr_retry) retries++;
      if (req_ready[0]) begin
        pulses++; w++;
        if (w <= 8) req_data[31:0] = 32'(w);
        else req_valid = '0;
      end
    end
    check("t1_ready_pulses", pulses, LIMIT);
    check("t1_fifo_count", fifo_count, LIMIT);
    check("t1_no_retry", retries, 0);
    bad = 0;
    for (int k = 0; k < LIMIT; k++) if (k >= fq.size() || fq[k] !== 32'(k + 1)) bad++;
    check("t1_fifo_content", bad, 0);

    // Full fifo blocks producer 2 until one word is read
    req_valid = 4'b0100; req_data[2*DW +: DW] = 32'hC0DE_0002;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= fifo_wr_en; end
    check("t3_blocked", seen, 0);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    wait_wr(ok);
    check("t3_wr_seen", ok, 1);
    check("t3_grant", grant_id, 2);
    check("t3_din", fifo_din, 32'hC0DE_0002);
    repeat (2) @(negedge clk);
    check("t3_ready", req_ready, 4'b0100);
    req_valid = '0;

    // All producers valid from reset: strict rotation at one word per 3 cycles
    do_reset();
    rd_req = 1'b1; req_valid = 4'b1111; last = 0;
    for (int k = 0; k < 8; k++) begin
      wait_wr(ok);
      check("t2_wr_seen", ok, 1);
      check("t2_grant", grant_id, k % N);
      if (k > 0) check("t2_interval", cyc - last, 3);
      last = cyc;
    end
    req_valid = '0;

    // Vector table: grant choice, data and completion pulse with its latency
    do_reset();
    rd_req = 1'b1;
    for (int e = 0; e < 9; e++) begin
      req_valid = tbl[e].valid;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA000_0000 + 32'(e * 256 + i);
      wait_wr(ok);
      check("tbl_wr_seen", ok, 1);
      check("tbl_grant", grant_id, tbl[e].grant);
      check("tbl_din", fifo_din, 32'hA000_0000 + 32'(e * 256 + tbl[e].grant));
      resp_mode = tbl[e].resp;
      lat = (tbl[e].resp == 2) ? TMO + 1 : 2;
      ready_acc = '0; pulse_acc = 1'b0;
      repeat (lat - 1) begin
        @(negedge clk);
        ready_acc |= req_ready; pulse_acc |= wr_retry | timeout_err;
      end
      check("tbl_early_pulse", {ready_acc, pulse_acc}, 5'd0);
      @(negedge clk);
      check("tbl_pulses", {req_ready, wr_retry, timeout_err}, {tbl[e].ready, tbl[e].retry, tbl[e].tmo});
      check("tbl_idle", busy, 0);
    end
    req_valid = '0;

    // Reset while waiting for an ack drops the write without a ready
    do_reset();
    resp_mode = 2; req_data[31:0] = 32'hDEAD_BEEF; req_valid = 4'b0001;
    wait_wr(ok);
    check("t6_wr_seen", ok, 1);
    @(negedge clk);
    check("t6_busy_wait", busy, 1);
    #1 reset_n = 1'b0;
    #1 check("t6_reset_outputs", {req_ready, fifo_wr_en, fifo_din, grant_id, busy, wr_retry, timeout_err}, 64'd0);
    req_valid = '0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= (|req_ready) | timeout_err | wr_retry | fifo_wr_en | busy; end
    check("t6_no_completion", seen, 0);

    // Randomized producers, fifo responses and reads against a transaction model
    do_reset();
    m_ptr = 0; pend = 0; pkind = 0; cur_g = 0; exp_g = 0; exp_wr = 1'b0; exp_d = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_ready_v = '0; exp_retry_v = 1'b0; exp_tmo_v = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pkind == 0) begin exp_ready_v[cur_g] = 1'b1; m_ptr = (cur_g + 1) % N; end
          else if (pkind == 1) exp_retry_v = 1'b1;
          else exp_tmo_v = 1'b1;
        end
      end
      check("rnd_pulses", {req_ready, wr_retry, timeout_err}, {exp_ready_v, exp_retry_v, exp_tmo_v});
      check("rnd_wr_en", fifo_wr_en, exp_wr);
      if (exp_wr) begin
        check("rnd_grant", grant_id, exp_g);
        check("rnd_din", fifo_din, exp_d);
        cur_g = exp_g;
        r = $urandom_range(0, 9);
        pkind = (r < 7) ? 0 : (r < 9) ? 1 : 2;
        resp_mode = pkind;
        pend = (pkind == 2) ? TMO + 1 : 2;
      end
      check("rnd_busy", busy, (pend > 0));
      for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = $urandom;
        end
      rd_req = ($urandom_range(0, 3) == 0);
      exp_wr = (pend == 0) && (f_cnt < LIMIT) && (|req_valid);
      if (exp_wr) begin
        exp_g = rr_pick(req_valid, m_ptr);
        exp_d = req_data[exp_g*DW +: DW];
      end
    end
    req_valid = '0; rd_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
